// File: rtl/gx4000_cart_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : gx4000_cart_reader_if
//  Purpose  : CPU-bus and SDRAM-side signal bundle for gx4000_cart_reader.
//  Signals  : plus_mode, cpu_addr[15:0], cpu_data_in[7:0], cpu_io_wr,
//             cpu_mem_rd, cpu_data_out[7:0], cpu_wait, rom_hit,
//             asic_page_en, sd_addr[24:0], sd_rd, sd_ack, sd_dout[7:0],
//             fetch_err
//  Modports : slave  - the cartridge reader (drives ROM data, wait, SDRAM req)
//             master - the CPU / SDRAM side driving the reader
//  Revision : 1.0 - initial release
// ============================================================================
interface gx4000_cart_reader_if;
  logic        plus_mode;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_io_wr;
  logic        cpu_mem_rd;
  logic [7:0]  cpu_data_out;
  logic        cpu_wait;
  logic        rom_hit;
  logic        asic_page_en;
  logic [24:0] sd_addr;
  logic        sd_rd;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        fetch_err;

  modport slave (
    input  plus_mode, cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_rd,
           sd_ack, sd_dout,
    output cpu_data_out, cpu_wait, rom_hit, asic_page_en,
           sd_addr, sd_rd, fetch_err
  );

  modport master (
    output plus_mode, cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_rd,
           sd_ack, sd_dout,
    input  cpu_data_out, cpu_wait, rom_hit, asic_page_en,
           sd_addr, sd_rd, fetch_err
  );
endinterface
`default_nettype wire

// File: rtl/gx4000_cart_reader.sv
`default_nettype none
// ============================================================================
//  Module   : gx4000_cart_reader
//  Purpose  : Serves Z80 ROM-window reads from cartridge data held in SDRAM.
//             Tracks the Plus mapping registers (RMR, RMR2, upper-ROM select)
//             from CPU I/O writes, maps each ROM read to an SDRAM byte address,
//             runs a req/ack fetch and stalls the CPU until data is back.
//  Ports    : clk_sys - system clock
//             reset   - synchronous active-high reset
//             bus     - gx4000_cart_reader_if.slave (CPU bus + SDRAM request)
//  Params   : CART_BASE - SDRAM byte address of cartridge page 0
//             TIMEOUT   - cycles to wait for sd_ack before aborting (1..255)
//  Options  : GX4000_CART_HITCACHE_EN - one-entry cache of the last fetch
//  Revision : 1.0 - initial release
// ============================================================================
module gx4000_cart_reader #(
  parameter logic [24:0] CART_BASE = 25'h0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  wire logic             clk_sys,
  input  wire logic             reset,
  gx4000_cart_reader_if.slave   bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] sd_addr_q, sd_addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        lower_dis_q, lower_dis_d;
  logic        upper_dis_q, upper_dis_d;
  logic [1:0]  loc_q, loc_d;
  logic [2:0]  lpage_q, lpage_d;
  logic [4:0]  upage_q, upage_d;

  // ---------------------------------------------------------------- I/O decode
  logic io_rmr, io_rmr2, io_upg, map_wr;

  assign io_rmr  = bus.cpu_io_wr && (bus.cpu_addr[15:8] == 8'h7F) &&
                   (bus.cpu_data_in[7:5] == 3'b100);
  assign io_rmr2 = bus.cpu_io_wr && (bus.cpu_addr[15:8] == 8'h7F) &&
                   (bus.cpu_data_in[7:5] == 3'b101) && bus.plus_mode;
  assign io_upg  = bus.cpu_io_wr && (bus.cpu_addr[15:8] == 8'hDF);
  assign map_wr  = io_rmr || io_rmr2 || io_upg;

  always_comb begin
    lower_dis_d = lower_dis_q;
    upper_dis_d = upper_dis_q;
    loc_d       = loc_q;
    lpage_d     = lpage_q;
    upage_d     = upage_q;
    if (io_rmr) begin
      lower_dis_d = bus.cpu_data_in[2];
      upper_dis_d = bus.cpu_data_in[3];
    end
    if (io_rmr2) begin
      loc_d   = bus.cpu_data_in[4:3];
      lpage_d = bus.cpu_data_in[2:0];
    end
    if (io_upg) begin
      // Bit 7 clear selects the default upper ROM (page 1).
      upage_d = bus.cpu_data_in[7] ? bus.cpu_data_in[4:0] : 5'd1;
    end
  end

  // ------------------------------------------------------------ window mapping
  // Outside Plus mode the stored RMR2 contents are masked so the lower ROM
  // falls back to page 0 at 0000-3FFF without losing the register values.
  logic [1:0]  eff_loc, lower_sel;
  logic [2:0]  eff_lpage;
  logic        lower_match, upper_match;
  logic [4:0]  page;
  logic [24:0] addr_calc;

  assign eff_loc   = bus.plus_mode ? loc_q   : 2'b00;
  assign eff_lpage = bus.plus_mode ? lpage_q : 3'b000;

  always_comb begin
    lower_sel = 2'b00;
    case (eff_loc)
      2'b01:   lower_sel = 2'b01;
      2'b10:   lower_sel = 2'b10;
      default: lower_sel = 2'b00;
    endcase
  end

  assign lower_match = !lower_dis_q && (bus.cpu_addr[15:14] == lower_sel);
  assign upper_match = !upper_dis_q && (bus.cpu_addr[15:14] == 2'b11);
  // Lower window has priority where both decode the same address.
  assign page        = lower_match ? {2'b00, eff_lpage} : upage_q;
  assign addr_calc   = CART_BASE + {6'd0, page, bus.cpu_addr[13:0]};

  assign bus.rom_hit      = bus.cpu_mem_rd && (lower_match || upper_match);
  assign bus.asic_page_en = (eff_loc == 2'b11);

  // ------------------------------------------------------------ fetch events
  logic fetch_ok, fetch_to, cache_hit;

  assign fetch_ok = (state_q == S_WAIT) && bus.sd_ack;
  assign fetch_to = (state_q == S_WAIT) && !bus.sd_ack &&
                    ((cnt_q + 8'd1) == TIMEOUT_C);

`ifdef GX4000_CART_HITCACHE_EN
  logic        cvalid_q, cvalid_d;
  logic [24:0] caddr_q, caddr_d;
  logic [7:0]  cdata_q, cdata_d;

  assign cache_hit = cvalid_q && (caddr_q == addr_calc);

  always_comb begin
    cvalid_d = cvalid_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    if (fetch_ok) begin
      cvalid_d = 1'b1;
      caddr_d  = sd_addr_q;
      cdata_d  = bus.sd_dout;
    end
    // A mapping change or an aborted fetch invalidates the entry, even if a
    // fill lands in the same cycle.
    if (map_wr || fetch_to) begin
      cvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cvalid_q <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= 8'hFF;
    end else begin
      cvalid_q <= cvalid_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    sd_addr_d = sd_addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rom_hit) begin
          sd_addr_d = addr_calc;
          if (cache_hit) begin
`ifdef GX4000_CART_HITCACHE_EN
            data_d  = cdata_q;
`endif
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fetch_ok) begin
          data_d  = bus.sd_dout;
          state_d = S_DONE;
        end else if (fetch_to) begin
          data_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // An aborted CPU cycle still finishes its fetch before returning here.
        if (!bus.cpu_mem_rd) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sd_addr_q   <= '0;
      data_q      <= 8'hFF;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      lower_dis_q <= 1'b0;
      upper_dis_q <= 1'b0;
      loc_q       <= 2'b00;
      lpage_q     <= 3'd0;
      upage_q     <= 5'd1;
    end else begin
      state_q     <= state_d;
      sd_addr_q   <= sd_addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      lower_dis_q <= lower_dis_d;
      upper_dis_q <= upper_dis_d;
      loc_q       <= loc_d;
      lpage_q     <= lpage_d;
      upage_q     <= upage_d;
    end
  end

  assign bus.sd_rd        = (state_q == S_REQ);
  assign bus.sd_addr      = sd_addr_q;
  assign bus.cpu_data_out = data_q;
  assign bus.fetch_err    = err_q;
  // Combinational so the stall reaches the CPU in the same cycle as the read.
  assign bus.cpu_wait     = bus.rom_hit && (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gx4000_cart_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gx4000_cart_reader
//  Purpose  : Self-checking bench for gx4000_cart_reader. Directed steps drive
//             the CPU side; an SDRAM responder answers sd_rd after a chosen
//             delay; expected SDRAM addresses and read data are queued when a
//             read is issued and popped when the DUT requests / completes.
//  Options  : GX4000_CART_HITCACHE_EN - also exercises the hit cache
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gx4000_cart_reader;

  localparam int TIMEOUT_TB = 255;

  logic clk_sys = 1'b0;
  logic reset;

  gx4000_cart_reader_if bus ();

  gx4000_cart_reader #(
    .CART_BASE (25'h0),
    .TIMEOUT   (TIMEOUT_TB)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          rd_count     = 0;
  int          exp_rd_count = 0;
  int          resp_dly     = 1;
  logic [7:0]  resp_data    = 8'h00;
  logic [24:0] addr_q [$];
  logic [7:0]  data_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every sd_rd pulse must match the oldest queued address.
  always @(negedge clk_sys) begin
    if (bus.sd_rd === 1'b1) begin
      logic [24:0] want;
      rd_count++;
      check("sd_rd_pending", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) begin
        want = addr_q.pop_front();
        check("sd_addr", 32'(bus.sd_addr), 32'(want));
      end
    end
  end

  // SDRAM model: one-cycle ack resp_dly cycles after sd_rd (never if <= 0).
  initial begin
    bus.sd_ack  = 1'b0;
    bus.sd_dout = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (bus.sd_rd === 1'b1 && resp_dly > 0) begin
        repeat (resp_dly) @(posedge clk_sys);
        #1;
        bus.sd_ack  = 1'b1;
        bus.sd_dout = resp_data;
        @(posedge clk_sys);
        #1;
        bus.sd_ack  = 1'b0;
      end
    end
  end

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    bus.cpu_addr    = a;
    bus.cpu_data_in = d;
    bus.cpu_io_wr   = 1'b1;
    @(posedge clk_sys); #1;
    bus.cpu_io_wr   = 1'b0;
  endtask

  // exp_n: number of cycles from the first read cycle up to and including the
  // first cycle with cpu_wait low.
  task automatic do_read(input string tag, input logic [15:0] a, input logic [24:0] exp_a,
                         input logic [7:0] d, input int dly, input bit fetch,
                         input logic [7:0] exp_d, input int exp_n);
    int         n;
    bit         seen_low;
    logic [7:0] want;
    if (fetch) begin
      addr_q.push_back(exp_a);
      exp_rd_count++;
    end
    data_q.push_back(exp_d);
    resp_dly  = dly;
    resp_data = d;
    @(posedge clk_sys); #1;
    bus.cpu_addr   = a;
    bus.cpu_mem_rd = 1'b1;
    n = 0;
    seen_low = 1'b0;
    while (!seen_low && n < 400) begin
      @(negedge clk_sys);
      n++;
      if (n == 1) check({tag, "_hit"}, 32'(bus.rom_hit), 32'd1);
      if (bus.cpu_wait == 1'b0) seen_low = 1'b1;
    end
    check({tag, "_len"}, 32'(n), 32'(exp_n));
    want = data_q.pop_front();
    check({tag, "_data"}, 32'(bus.cpu_data_out), 32'(want));
    @(posedge clk_sys); #1;
    bus.cpu_mem_rd = 1'b0;
    @(posedge clk_sys); #1;
    check({tag, "_rdcnt"}, 32'(rd_count), 32'(exp_rd_count));
  endtask

  task automatic check_nohit(input string tag, input logic [15:0] a);
    @(posedge clk_sys); #1;
    bus.cpu_addr   = a;
    bus.cpu_mem_rd = 1'b1;
    @(negedge clk_sys);
    check({tag, "_hit"}, 32'(bus.rom_hit), 32'd0);
    check({tag, "_wait"}, 32'(bus.cpu_wait), 32'd0);
    repeat (3) @(negedge clk_sys);
    check({tag, "_rdcnt"}, 32'(rd_count), 32'(exp_rd_count));
    @(posedge clk_sys); #1;
    bus.cpu_mem_rd = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.plus_mode   = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
    bus.cpu_io_wr   = 1'b0;
    bus.cpu_mem_rd  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk_sys);
    check("rst_data", 32'(bus.cpu_data_out), 32'hFF);
    check("rst_err", 32'(bus.fetch_err), 32'd0);
    check("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
    check("rst_sd_addr", 32'(bus.sd_addr), 32'd0);
    check("rst_asic", 32'(bus.asic_page_en), 32'd0);

    // Basic read, ack two cycles after sd_rd
    do_read("rd0006", 16'h0006, 25'h0006, 8'h3C, 2, 1'b1, 8'h3C, 5);

    // RMR2: loc=01, lpage=7
    bus.plus_mode = 1'b1;
    io_write(16'h7F00, 8'hAF);
    @(negedge clk_sys);
    check("asic_loc01", 32'(bus.asic_page_en), 32'd0);
    do_read("rd4123", 16'h4123, 25'h1C123, 8'h5A, 1, 1'b1, 8'h5A, 4);
    check_nohit("nohit0123", 16'h0123);

    // Upper ROM select
    io_write(16'hDF00, 8'h85);
    do_read("rdC010_p5", 16'hC010, 25'h14010, 8'h11, 3, 1'b1, 8'h11, 6);
    io_write(16'hDF00, 8'h07);
    do_read("rdC010_p1", 16'hC010, 25'h04010, 8'h22, 1, 1'b1, 8'h22, 4);

    // loc=11 gives the ASIC page; leaving Plus mode masks RMR2
    io_write(16'h7F00, 8'hB8);
    @(negedge clk_sys);
    check("asic_loc11", 32'(bus.asic_page_en), 32'd1);
    @(posedge clk_sys); #1;
    bus.plus_mode = 1'b0;
    @(negedge clk_sys);
    check("asic_noplus", 32'(bus.asic_page_en), 32'd0);
    do_read("rd2000_noplus", 16'h2000, 25'h02000, 8'h33, 1, 1'b1, 8'h33, 4);
    bus.plus_mode = 1'b1;

    // Both ROMs disabled
    io_write(16'h7F00, 8'h8C);
    check_nohit("dis0000", 16'h0000);
    check_nohit("disC000", 16'hC000);

    // Re-enable, then time out
    io_write(16'h7F00, 8'h80);
    do_read("timeout", 16'h0100, 25'h00100, 8'h99, -1, 1'b1, 8'hFF, TIMEOUT_TB + 3);
    check("timeout_err", 32'(bus.fetch_err), 32'd1);

    // Reset during WAIT; the late ack must be ignored
    resp_dly  = 5;
    resp_data = 8'hE7;
    addr_q.push_back(25'h00200);
    exp_rd_count++;
    @(posedge clk_sys); #1;
    bus.cpu_addr   = 16'h0200;
    bus.cpu_mem_rd = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    reset          = 1'b1;
    bus.cpu_mem_rd = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    check("rstw_err", 32'(bus.fetch_err), 32'd0);
    check("rstw_data", 32'(bus.cpu_data_out), 32'hFF);
    repeat (5) @(negedge clk_sys);
    check("rstw_ack_ignored", 32'(bus.cpu_data_out), 32'hFF);
    check("rstw_rdcnt", 32'(rd_count), 32'(exp_rd_count));

    // Normal operation after reset
    do_read("rd0300", 16'h0300, 25'h00300, 8'h77, 1, 1'b1, 8'h77, 4);

`ifdef GX4000_CART_HITCACHE_EN
    do_read("c_miss", 16'h0006, 25'h00006, 8'h3C, 1, 1'b1, 8'h3C, 4);
    do_read("c_hit", 16'h0006, 25'h00006, 8'h00, 1, 1'b0, 8'h3C, 2);
    io_write(16'hDF00, 8'h85);
    do_read("c_inval", 16'h0006, 25'h00006, 8'h4B, 1, 1'b1, 8'h4B, 4);
`endif

    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gx4000_cart_reader.md
# gx4000_cart_reader

Read-side counterpart of the GX4000 cartridge loader: serves Z80 memory reads from cartridge ROM stored in SDRAM. It decodes the Plus ROM mapping registers (RMR, RMR2, upper-ROM select) from CPU I/O writes and resolves each ROM-window read to an SDRAM byte address. It then runs a request/acknowledge fetch and stretches the CPU cycle with a wait signal until data is returned. It sits between the CPU bus and the SDRAM arbiter, beside the PlusMode top-level.

## Interface
- CART_BASE, 25'h0, SDRAM byte address of cartridge page 0 (same base the loader writes to)
- TIMEOUT, 255, cycles to wait for sd_ack before aborting a fetch (8-bit counter, 1..255)
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- plus_mode  in  1  enables RMR2 decoding; when 0, RMR2 writes are ignored and the lower ROM is fixed at page 0, 0000-3FFF
- cpu_addr  in  16  CPU address
- cpu_data_in  in  8  CPU write data
- cpu_io_wr  in  1  I/O write strobe, one cycle per write
- cpu_mem_rd  in  1  memory read, level held until cpu_wait is low
- cpu_data_out  out  8  ROM data, valid when rom_hit=1 and cpu_wait=0
- cpu_wait  out  1  stall request to CPU
- rom_hit  out  1  current read targets an enabled ROM window
- asic_page_en  out  1  RMR2 location=11; the 4000-7FFF window belongs to the ASIC
- sd_addr  out  25  SDRAM byte address
- sd_rd  out  1  SDRAM read request, one-cycle pulse
- sd_ack  in  1  SDRAM data valid, one-cycle pulse
- sd_dout  in  8  SDRAM read data
- fetch_err  out  1  sticky; set on timeout, cleared by reset

## Operation
- I/O decode (on cpu_io_wr):
  - Address 7Fxx with data[7:5]=100 (RMR): lower_dis=data[2], upper_dis=data[3].
  - Address 7Fxx with data[7:5]=101 (RMR2), only when plus_mode=1: loc=data[4:3], lpage=data[2:0].
  - Address DFxx: data[7]=1 gives upage=data[4:0]; data[7]=0 gives upage=1.
- Lower window: 0000-3FFF for loc 00 and 11, 4000-7FFF for loc 01, 8000-BFFF for loc 10. It is active when lower_dis=0. Page = {2'b00,lpage}.
- Upper window: C000-FFFF, active when upper_dis=0. Page = upage.
- If both windows match, the lower window wins.
- rom_hit is combinational: cpu_mem_rd & window match.
- sd_addr = CART_BASE + {page[4:0],addr[13:0]}, computed as a 25-bit add with wrap-around.
- FSM states:
  - IDLE: on rom_hit, capture sd_addr and go to REQ.
  - REQ: sd_rd=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT: on sd_ack, latch sd_dout into the data register and go to DONE. If the counter reaches TIMEOUT, load 8'hFF, set fetch_err and go to DONE.
  - DONE: hold data; return to IDLE when cpu_mem_rd=0.
- cpu_wait = rom_hit & (state != DONE). It is combinational, so the wait is asserted in the same cycle as the read.
- sd_ack outside WAIT is ignored.
- A register write during a fetch takes effect immediately but does not alter the captured sd_addr.
- cpu_mem_rd dropping in REQ or WAIT (aborted cycle): the FSM completes the fetch, then returns to IDLE from DONE.
- Reset values:
  - State IDLE, sd_rd=0, sd_addr=0, cpu_data_out=8'hFF, fetch_err=0.
  - lower_dis=0, upper_dis=0, loc=00, lpage=0, upage=1.
- Reset during WAIT drops the transaction; any later sd_ack is ignored.

## Timing
- The register update is visible on the cycle after cpu_io_wr.
- Read latency, measured from the first cycle cpu_mem_rd is high with rom_hit:
  - Cycle 0: IDLE.
  - Cycle 1: REQ, sd_rd=1.
  - Cycle 2 onward: WAIT.
  - DONE is entered on the cycle after sd_ack; cpu_wait falls in that same cycle.
  - Minimum is 4 cycles for a one-cycle SDRAM response.
- Timeout goes to DONE TIMEOUT+1 cycles after REQ.
- Back-to-back reads require at least one cycle of cpu_mem_rd=0 between them.

## Configuration
- GX4000_CART_HITCACHE_EN defined: a one-entry cache of the last fetched sd_addr and data, plus a valid bit.
  - On a matching read, IDLE goes straight to DONE with no sd_rd, giving a 1-cycle wait.
  - The valid bit is cleared by reset, by any mapping-register write, and by a timeout.
- Macro undefined: every ROM read issues an SDRAM request.

## Test plan
- After reset, read 0006 with sd_ack 2 cycles after sd_rd and sd_dout=8'h3C -> sd_addr=CART_BASE+25'h0006, one sd_rd pulse, cpu_data_out=8'h3C, cpu_wait low 5 cycles after the read starts.
- plus_mode=1: write 7F00<-8'hAF (RMR2: loc=01, lpage=7), then read 4123 -> sd_addr=CART_BASE+25'h1C123 and asic_page_en=0. Reading 0123 -> rom_hit=0.
- Write DF00<-8'h85, then read C010 -> sd_addr=CART_BASE+25'h14010. Write DF00<-8'h07 -> page becomes 1 (sd_addr=CART_BASE+25'h4010).
- Write RMR 7F00<-8'h8C (both ROMs disabled), then read 0000 and C000 -> rom_hit=0, cpu_wait=0, no sd_rd.
- Never ack -> cpu_data_out=8'hFF and fetch_err=1 at TIMEOUT+1 cycles after sd_rd. Apply reset during WAIT, then ack -> state IDLE, fetch_err=0, ack ignored.
- With GX4000_CART_HITCACHE_EN: read 0006 twice -> a single sd_rd and a 1-cycle wait on the second read. Write DFxx between the reads -> two sd_rd pulses.
